// File: rtl/call_panel.sv
// call_panel: debounced call buttons latch per-floor requests, cleared when the cab is parked there with the door open.
// Optional CALL_CANCEL_EN: a press on a pending, unserved floor cancels its request.
module call_panel #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic btn1,
    input  logic btn2,
    input  logic btn3,
    input  logic floor1,
    input  logic floor2,
    input  logic floor3,
    input  logic door,
    input  logic moving,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic any_pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef CALL_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic [7:0] w_raw;
    logic [7:0] r_meta;
    logic [7:0] r_sync;
    logic [2:0] w_btn_s;
    logic [2:0] w_served;
    logic [2:0] w_led;
    logic       r_any;

    // Bit order: {moving, door, floor3..1, btn3..1}
    assign w_raw    = {moving, door, floor3, floor2, floor1, btn3, btn2, btn1};
    assign w_btn_s  = r_sync[2:0];
    assign w_served = r_sync[5:3] & {3{r_sync[6] & ~r_sync[7]}};

    always_ff @(posedge clk_50 or negedge rst_n)
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_any  <= 1'b0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            r_any  <= |w_led;
        end

    for (genvar f = 0; f < 3; f++) begin : g_floor
        logic          r_stable;
        logic          r_stable_d;
        logic          r_led;
        logic [CW-1:0] r_cnt;
        logic          w_press;

        assign w_press  = r_stable & ~r_stable_d;
        assign w_led[f] = r_led;

        always_ff @(posedge clk_50 or negedge rst_n)
            if (!rst_n) begin
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_cnt      <= '0;
                r_led      <= 1'b0;
            end else begin
                r_stable_d <= r_stable;
                if (w_btn_s[f] == r_stable)
                    r_cnt <= '0;
                else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= w_btn_s[f];
                    r_cnt    <= '0;
                end else
                    r_cnt <= r_cnt + 1'b1;
                // Service wins over a simultaneous press
                if (w_served[f])
                    r_led <= 1'b0;
                else if (w_press)
                    r_led <= CANCEL ? ~r_led : 1'b1;
            end
    end

    assign led1        = w_led[0];
    assign led2        = w_led[1];
    assign led3        = w_led[2];
    assign any_pending = r_any;
endmodule

// File: tb/tb_call_panel.sv
// tb_call_panel: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_call_panel;
    localparam int D = 4;
`ifdef CALL_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    typedef struct {
        logic [2:0] btn;
        logic [2:0] floor;
        logic       door;
        logic       moving;
        int         hold;
        logic [3:0] exp;
    } vec_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b1;
    logic [2:0] btn = '0;
    logic [2:0] floor = '0;
    logic door = 1'b0;
    logic moving = 1'b0;
    logic led1, led2, led3, any_pending;
    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]   m_s1, m_s2;
    logic [2:0]   m_stable, m_stable_d, m_led;
    logic         m_any;
    logic [D-1:0] m_win [3];

    always #5 clk_50 = ~clk_50;

    call_panel #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_50(clk_50), .rst_n(rst_n),
        .btn1(btn[0]), .btn2(btn[1]), .btn3(btn[2]),
        .floor1(floor[0]), .floor2(floor[1]), .floor3(floor[2]),
        .door(door), .moving(moving),
        .led1(led1), .led2(led2), .led3(led3), .any_pending(any_pending)
    );

    function automatic logic [3:0] outs();
        return {any_pending, led3, led2, led1};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (any,led3,led2,led1) at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [2:0] b, input logic [2:0] f, input logic d, input logic m);
        btn = b; floor = f; door = d; moving = m;
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        rst_n = 1'b0;
        set_in(3'b000, 3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clk_50);
        rst_n = 1'b1;
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_led = '0; m_any = 1'b0;
        for (int f = 0; f < 3; f++) m_win[f] = '0;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    // One rising edge of the reference: an accepted level flips once the last D synced samples all disagree with it
    task automatic model_step(input logic [7:0] raw);
        logic [2:0] press;
        logic       parked;
        press  = m_stable & ~m_stable_d;
        parked = m_s2[6] & ~m_s2[7];
        m_any  = |m_led;
        for (int f = 0; f < 3; f++)
            if (m_s2[3+f] && parked) m_led[f] = 1'b0;
            else if (press[f]) m_led[f] = CANCEL ? ~m_led[f] : 1'b1;
        m_stable_d = m_stable;
        for (int f = 0; f < 3; f++) begin
            m_win[f] = {m_win[f][D-2:0], m_s2[f]};
            if (m_win[f] == {D{~m_stable[f]}}) m_stable[f] = ~m_stable[f];
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    initial begin
        vec_t tbl[$];
        #1 rst_n = 1'b0;

        // Vector table
        tbl.push_back('{3'b001, 3'b000, 1'b0, 1'b0, 10, 4'b1001});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  8, 4'b1001});
        tbl.push_back('{3'b010, 3'b000, 1'b0, 1'b0, 10, 4'b1011});
        tbl.push_back('{3'b000, 3'b001, 1'b1, 1'b0,  5, 4'b1010});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  8, 4'b1010});
        tbl.push_back('{3'b100, 3'b000, 1'b0, 1'b0, 10, 4'b1110});
        tbl.push_back('{3'b000, 3'b100, 1'b1, 1'b1, 20, 4'b1110});
        tbl.push_back('{3'b000, 3'b100, 1'b1, 1'b0,  5, 4'b1010});
        tbl.push_back('{3'b000, 3'b010, 1'b1, 1'b0,  5, 4'b0000});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  8, 4'b0000});
        tbl.push_back('{3'b010, 3'b000, 1'b0, 1'b0, 10, 4'b1010});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  8, 4'b1010});
        tbl.push_back('{3'b010, 3'b000, 1'b0, 1'b0, 10, CANCEL ? 4'b0000 : 4'b1010});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  8, CANCEL ? 4'b0000 : 4'b1010});
        tbl.push_back('{3'b111, 3'b000, 1'b0, 1'b0, 10, 4'b1111});
        tbl.push_back('{3'b000, 3'b111, 1'b1, 1'b0,  5, 4'b0000});
        tbl.push_back('{3'b000, 3'b000, 1'b0, 1'b0,  3, 4'b0000});

        do_reset();
        check("reset", outs(), 4'b0000);
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].btn, tbl[i].floor, tbl[i].door, tbl[i].moving);
            hold(tbl[i].hold);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Clean press latency on btn2
        do_reset();
        btn = 3'b010;
        for (int k = 1; k <= 9; k++) begin
            hold(1);
            check($sformatf("latency_e%0d", k), outs(), {k >= 8 ? 1'b1 : 1'b0, 1'b0, k >= 7 ? 1'b1 : 1'b0, 1'b0});
        end

        // Glitch rejection on btn1
        do_reset();
        btn = 3'b001; hold(3);
        btn = 3'b000; hold(2);
        btn = 3'b001; hold(3);
        btn = 3'b000; hold(10);
        check("glitch", outs(), 4'b0000);
        btn = 3'b001; hold(10);
        check("glitch_then_hold", outs(), 4'b1001);

        // Service clear latency and press discarded during service
        do_reset();
        btn = 3'b100; hold(10);
        btn = 3'b000; hold(8);
        check("svc_pre", outs(), 4'b1100);
        set_in(3'b000, 3'b100, 1'b1, 1'b0);
        hold(2);
        check("svc_e2", outs(), 4'b1100);
        hold(1);
        check("svc_e3", outs(), 4'b1000);
        btn = 3'b100; hold(10);
        check("svc_press", outs(), 4'b0000);
        set_in(3'b000, 3'b000, 1'b0, 1'b0);
        hold(8);
        check("svc_after", outs(), 4'b0000);

        // Moving cab does not clear
        do_reset();
        btn = 3'b001; hold(10);
        btn = 3'b000; hold(8);
        set_in(3'b000, 3'b001, 1'b1, 1'b1);
        hold(20);
        check("moving_hold", outs(), 4'b1001);
        moving = 1'b0;
        hold(3);
        check("moving_stop", outs(), 4'b1000);

        // Reset mid-operation with btn1 held
        do_reset();
        btn = 3'b111; hold(10);
        check("mid_pre", outs(), 4'b1111);
        btn = 3'b001; hold(2);
        #2 rst_n = 1'b0;
        #1 check("mid_async", outs(), 4'b0000);
        hold(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            hold(1);
            check($sformatf("mid_rel_e%0d", k), outs(), {k >= 8 ? 1'b1 : 1'b0, 2'b00, k >= 7 ? 1'b1 : 1'b0});
        end

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int f = 0; f < 3; f++)
                if ($urandom_range(7) == 0) btn[f] = ~btn[f];
            if ($urandom_range(15) == 0) floor = 3'($urandom_range(7));
            if ($urandom_range(9) == 0) door = ~door;
            if ($urandom_range(9) == 0) moving = ~moving;
            @(posedge clk_50);
            model_step({moving, door, floor, btn});
            @(negedge clk_50);
            check("random", outs(), {m_any, m_led});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/call_panel.md
# call_panel

Hall/cab call-button front end for the three-floor elevator. It debounces three raw pushbuttons, latches each accepted press as a pending request, and drives the `led1..led3` request lines consumed by the movement controller. It clears a request when `floor*`, `door` and `moving` report that the elevator is parked at that floor with the door open. It runs on `clk_50`, upstream of the frequency divider and movement logic, and closes the request/serve loop from the requesting side.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive `clk_50` cycles a synchronized button level must differ from the accepted level before the change is accepted. Legal range is ≥1. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- `clk_50`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn1`, `btn2`, `btn3`  in  1 each  raw pushbuttons, active-high, asynchronous, may bounce.
- `floor1`, `floor2`, `floor3`  in  1 each  current-floor indicators from the movement block. They come from the slow clock domain.
- `door`  in  1  door-open indicator from the movement block.
- `moving`  in  1  cab-in-motion indicator from the movement block.
- `led1`, `led2`, `led3`  out  1 each  pending request per floor. These drive the movement block's `led*` inputs.
- `any_pending`  out  1  OR of `led1..led3`, registered.

## Operation
- **Input synchronization:** every input except `clk_50`/`rst_n` passes through a 2-FF synchronizer. That covers `btn*`, `floor*`, `door` and `moving`.
- **Per-button debouncer:**
  - State: `stable_i` (accepted level) and `cnt_i`.
  - If the synced button equals `stable_i`: `cnt_i` goes to 0.
  - Otherwise, if `cnt_i == DEBOUNCE_CYCLES-1`: `stable_i` takes the synced level and `cnt_i` goes to 0.
  - Otherwise: `cnt_i` increments.
  - A pulse shorter than DEBOUNCE_CYCLES synced cycles never changes `stable_i`.
- **Press event:** one-cycle pulse `press_i` when `stable_i` rises 0→1. Releases (1→0) generate nothing.
- **Serve condition:** `served_i = floor_i_s & door_s & ~moving_s` (all synced).
- **Request latch `led_i`:**
  - Clear when `served_i`.
  - Else set on `press_i`.
  - Else hold.
  - Clear has priority: a press arriving while its floor is being served is discarded.
- **Independence:** floors are independent. Simultaneous presses on several buttons all latch in the same cycle.
- **Inconsistent floor indications:** multiple `floor*` high at once is not filtered; each served floor clears independently.

## Timing
- **Reset values (asynchronous):** `led1..3 = 0`, `any_pending = 0`, all synchronizers 0, `stable_i = 0`, `cnt_i = 0`.
- **Press latency:** with `btn_i` rising cleanly and held, `led_i` is high after rising edge number DEBOUNCE_CYCLES+3 of `clk_50`. That is 2 synchronizer edges, DEBOUNCE_CYCLES debounce edges, and 1 latch edge.
- **Clear latency:** after `served_i`'s raw inputs become true and stay stable, `led_i` is low after 3 `clk_50` edges. The synchronizer accounts for 2 of those.
- **`any_pending`** lags the `led*` outputs by 1 edge.
- **Reset mid-operation:** pending requests and in-progress debounce counts are lost immediately on `rst_n` low.
- **Button held through reset release:** `stable_i` restarts at 0, so the held button is accepted as a new press DEBOUNCE_CYCLES+3 edges after release.
- **Bounce during debounce:** any synced sample equal to `stable_i` restarts the count from 0.

## Configuration
- **`CALL_CANCEL_EN` defined:** a `press_i` while `led_i` is already 1, and `served_i` is 0, clears `led_i`. The press toggles the request.
- **`CALL_CANCEL_EN` undefined:** a press on an already-pending floor is ignored, and `led_i` stays 1.
- In both builds `served_i` keeps clear priority over any press.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4, reset released, `btn2` steps 0→1 and is held → `led2` rises exactly at edge 7 after the step, and `any_pending` at edge 8. `led1` and `led3` stay 0.
- **Glitch rejection:** `btn1` high for 3 cycles, low for 2, high for 3 → `led1` stays 0. Then `btn1` held high for 10 cycles → `led1` = 1.
- **Service clear:** `led3` = 1, then `floor3=1`, `door=1`, `moving=0` → `led3` = 0 after 3 edges. A `btn3` press completing during service leaves `led3` = 0.
- **Moving does not clear:** `led1` = 1, `floor1=1`, `door=1`, `moving=1` held for 20 cycles → `led1` stays 1.
- **Re-press on a pending floor:** with `btn2` pressed twice while `led2` = 1 → `led2` = 0 after the second press if `CALL_CANCEL_EN` is defined, and stays 1 if it is undefined.
- **Reset mid-operation:** all three leds = 1, `rst_n` pulsed low → all outputs 0 asynchronously. With `btn1` held through the pulse, `led1` = 1 again DEBOUNCE_CYCLES+3 edges after `rst_n` rises.
